// File: rtl/debug_pkg.sv
// Shared constants and types for the target-side debug port.
package debug_pkg;

  // tg_force register bit positions.
  localparam int unsigned TGF_HOLD     = 0;
  localparam int unsigned TGF_LOAD_EXR = 1;
  localparam int unsigned TGF_EXEC     = 2;

  // bus_ctrl register bit positions (bit 0 is unused).
  localparam int unsigned BUS_TG_RESET = 1;
  localparam int unsigned BUS_DIVERT   = 2;

  // A breakpoint register holding this address never matches.
  localparam logic [15:0] BP_DISABLED = 16'hffff;

  // Target execution state as seen by the debug port.
  typedef enum logic [0:0] {
    Run  = 1'b0,
    Halt = 1'b1
  } dbg_state_e;

endpackage

// File: rtl/bp_comparator.sv
// One PC breakpoint: address register, one-shot pass flag, sticky hit status.
module bp_comparator
  import debug_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,     // full reset: also disables the address
  input  logic         clr_i,       // target reset: clears status and pass only
  input  logic         hit_en_i,    // hits only count while the FSM is in Run
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         fetch_i,
  input  logic [W-1:0] pc_i,
  output logic         status_o,
  output logic         status_d_o   // next-state status, lets the FSM react in the same cycle
);

  localparam logic [W-1:0] Disabled = W'(BP_DISABLED);

  logic [W-1:0] addr_q, addr_d;
  logic         pass_q, pass_d;
  logic         status_q, status_d;
  logic         match;
  logic         hit;

  assign match = fetch_i && (pc_i == addr_q);
  assign hit   = hit_en_i && match && (addr_q != Disabled) && !pass_q;

  // Next-state: a write beats a simultaneous hit; target reset beats everything but the address.
  always_comb begin
    addr_d   = addr_q;
    pass_d   = pass_q;
    status_d = status_q;
    if (fetch_i && (pc_i != addr_q)) begin
      pass_d = 1'b0;
    end
    if (hit) begin
      status_d = 1'b1;
    end
    if (wr_i) begin
      addr_d   = wdata_i;
      status_d = 1'b0;
      pass_d   = 1'b1;
    end
    if (clr_i) begin
      status_d = 1'b0;
      pass_d   = 1'b0;
    end
  end

  // State registers; the address survives a target-only reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q   <= Disabled;
      pass_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      pass_q   <= pass_d;
      status_q <= status_d;
    end
  end

  assign status_o   = status_q;
  assign status_d_o = status_d;

endmodule

// File: rtl/target_debug_port.sv
// Target-side debug responder: code mux, breakpoints, halt/step/force-load control.
module target_debug_port
  import debug_pkg::*;
#(
  parameter int unsigned NUM_BP = 4,
  parameter int unsigned W      = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [2:0]        bus_ctrl_i,
  input  logic [2:0]        tg_force_i,
  input  logic [W-1:0]      tg_code_in_i,
  input  logic [NUM_BP-1:0] bp_wr_i,
  input  logic [W-1:0]      bp_wdata_i,
  output logic [NUM_BP-1:0] bp_status_o,
  output logic [W-1:0]      exr_shadow_o,
  output logic [W-1:0]      tg_to_visor_reg_o,
  input  logic [W-1:0]      rom_data_i,
  input  logic [W-1:0]      tg_pc_i,
  input  logic              tg_fetch_i,
  input  logic [W-1:0]      tg_exr_i,
  input  logic              tg_r15_we_i,
  input  logic [W-1:0]      tg_r15_data_i,
  output logic [W-1:0]      tg_code_data_o,
  output logic              tg_run_o,
  output logic              tg_load_exr_o,
  output logic              tg_reset_out_o
);

  dbg_state_e        state_q;
  logic              tg_run_q;
  logic              load_exr_q;
  logic [W-1:0]      exr_shadow_q;
  logic [W-1:0]      r15_q;
  logic [2:0]        force_q;
  logic [NUM_BP-1:0] status;
  logic [NUM_BP-1:0] status_d;
  logic              tg_reset;
  logic              hit_en;
  logic              hold;
  logic              exec_rise;
  logic              load_rise;
  logic              unused_bus;

  assign unused_bus = bus_ctrl_i[0];

  assign tg_reset  = reset_i | bus_ctrl_i[BUS_TG_RESET];
  assign hold      = tg_force_i[TGF_HOLD];
  assign exec_rise = tg_force_i[TGF_EXEC] & ~force_q[TGF_EXEC];
  assign load_rise = tg_force_i[TGF_LOAD_EXR] & ~force_q[TGF_LOAD_EXR];
  // Gate on state, not tg_run, so a forced step can never hit a breakpoint.
  assign hit_en    = (state_q == Run);

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    bp_comparator #(
      .W(W)
    ) u_bp (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .clr_i      (tg_reset),
      .hit_en_i   (hit_en),
      .wr_i       (bp_wr_i[i]),
      .wdata_i    (bp_wdata_i),
      .fetch_i    (tg_fetch_i),
      .pc_i       (tg_pc_i),
      .status_o   (status[i]),
      .status_d_o (status_d[i])
    );
  end

  // Run/halt FSM with registered run, load pulse, exr capture and r15 mirror.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= Run;
      tg_run_q     <= 1'b1;
      load_exr_q   <= 1'b0;
      exr_shadow_q <= '0;
      r15_q        <= '0;
      force_q      <= '0;
    end else begin
      force_q    <= tg_force_i;
      load_exr_q <= 1'b0;
      if (tg_r15_we_i) begin
        r15_q <= tg_r15_data_i;
      end
      if (bus_ctrl_i[BUS_TG_RESET]) begin
        state_q  <= Run;
        tg_run_q <= 1'b1;
      end else begin
        unique case (state_q)
          Run: begin
            if ((|status_d) || hold) begin
              state_q      <= Halt;
              tg_run_q     <= 1'b0;
              exr_shadow_q <= tg_exr_i;
            end else begin
              tg_run_q <= 1'b1;
            end
          end
          Halt: begin
            // Release looks at next-state status so the clearing write frees the target at once.
            if ((status_d == '0) && !hold) begin
              state_q  <= Run;
              tg_run_q <= 1'b1;
            end else begin
              tg_run_q   <= exec_rise;
              load_exr_q <= load_rise;
            end
          end
          default: begin
            state_q  <= Run;
            tg_run_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tg_code_data_o    = bus_ctrl_i[BUS_DIVERT] ? tg_code_in_i : rom_data_i;
  assign tg_reset_out_o    = tg_reset;
  assign tg_run_o          = tg_run_q;
  assign tg_load_exr_o     = load_exr_q;
  assign bp_status_o       = status;
  assign exr_shadow_o      = exr_shadow_q;
  assign tg_to_visor_reg_o = r15_q;

endmodule
